// File: rtl/i2s_tx_serializer.sv
// Stereo I2S transmitter: single-entry sample buffer, divided mclk/sclk/lrclk,
// MSB-first Philips framing in 32-bit slots with zero padding, underrun flag.
module i2s_tx_serializer #(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned MCLK_HALF    = 4,
    parameter int unsigned SCLK_HALF    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [SAMPLE_WIDTH-1:0] sample_left,
    input  logic [SAMPLE_WIDTH-1:0] sample_right,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    underrun,
    output logic                    i2s_mclk,
    output logic                    i2s_sclk,
    output logic                    i2s_lrclk,
    output logic                    i2s_sdata
);

    localparam int unsigned MCNT_W = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
    localparam int unsigned SCNT_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(MCLK_HALF - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SCLK_HALF - 1);

    logic [MCNT_W-1:0]       mcnt_q, mcnt_d;
    logic [SCNT_W-1:0]       scnt_q, scnt_d;
    logic                    mclk_q, mclk_d;
    logic                    sclk_q, sclk_d;
    logic [5:0]              bit_cnt_q, bit_cnt_d;
    logic                    lrclk_q, lrclk_d;
    logic                    sdata_q, sdata_d;
    logic [SAMPLE_WIDTH-1:0] buf_l_q, buf_l_d;
    logic [SAMPLE_WIDTH-1:0] buf_r_q, buf_r_d;
    logic                    buf_full_q, buf_full_d;
    logic [SAMPLE_WIDTH-1:0] cur_l_q, cur_l_d;
    logic [SAMPLE_WIDTH-1:0] cur_r_q, cur_r_d;
    logic                    underrun_q, underrun_d;
    logic                    ready_q, ready_d;

    logic                    sclk_fall;
    logic [4:0]              slot_k;
    logic [SAMPLE_WIDTH-1:0] slot_word;
    logic [SAMPLE_WIDTH-1:0] slot_shift;

    // Next-state: dividers, bit counter, frame load, serial bit and handshake.
    always_comb begin
        mcnt_d     = mcnt_q;
        mclk_d     = mclk_q;
        scnt_d     = scnt_q;
        sclk_d     = sclk_q;
        bit_cnt_d  = bit_cnt_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        buf_l_d    = buf_l_q;
        buf_r_d    = buf_r_q;
        buf_full_d = buf_full_q;
        cur_l_d    = cur_l_q;
        cur_r_d    = cur_r_q;
        underrun_d = 1'b0;
        ready_d    = 1'b0;
        sclk_fall  = 1'b0;
        slot_k     = '0;
        slot_word  = '0;
        slot_shift = '0;

        if (!enable) begin
            mcnt_d     = '0;
            mclk_d     = 1'b0;
            scnt_d     = '0;
            sclk_d     = 1'b0;
            bit_cnt_d  = 6'd63;
            lrclk_d    = 1'b0;
            sdata_d    = 1'b0;
            buf_full_d = 1'b0;
            cur_l_d    = '0;
            cur_r_d    = '0;
        end else begin
            if (mcnt_q == MCNT_LAST) begin
                mcnt_d = '0;
                mclk_d = ~mclk_q;
            end else begin
                mcnt_d = mcnt_q + MCNT_W'(1);
            end

            if (scnt_q == SCNT_LAST) begin
                scnt_d    = '0;
                sclk_d    = ~sclk_q;
                sclk_fall = sclk_q;
            end else begin
                scnt_d = scnt_q + SCNT_W'(1);
            end

            if (sclk_fall) begin
                bit_cnt_d = bit_cnt_q + 6'd1;
                if (bit_cnt_q == 6'd63) begin
                    if (buf_full_q) begin
                        cur_l_d    = buf_l_q;
                        cur_r_d    = buf_r_q;
                        buf_full_d = 1'b0;
                    end else begin
                        cur_l_d    = '0;
                        cur_r_d    = '0;
                        underrun_d = 1'b1;
                    end
                end
                lrclk_d   = bit_cnt_d[5];
                slot_k    = bit_cnt_d[4:0];
                slot_word = bit_cnt_d[5] ? cur_r_d : cur_l_d;
                if (slot_k != 5'd0 && 32'(slot_k) <= SAMPLE_WIDTH) begin
                    slot_shift = slot_word >> (SAMPLE_WIDTH - 32'(slot_k));
                    sdata_d    = slot_shift[0];
                end else begin
                    sdata_d = 1'b0;
                end
            end

            // ready is registered from ~buf_full, so a transfer never meets a full buffer
            if (sample_valid && ready_q) begin
                buf_l_d    = sample_left;
                buf_r_d    = sample_right;
                buf_full_d = 1'b1;
            end

            ready_d = ~buf_full_d;
        end
    end

    // State register with asynchronous return to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt_q     <= '0;
            mclk_q     <= 1'b0;
            scnt_q     <= '0;
            sclk_q     <= 1'b0;
            bit_cnt_q  <= 6'd63;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            buf_l_q    <= '0;
            buf_r_q    <= '0;
            buf_full_q <= 1'b0;
            cur_l_q    <= '0;
            cur_r_q    <= '0;
            underrun_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            mcnt_q     <= mcnt_d;
            mclk_q     <= mclk_d;
            scnt_q     <= scnt_d;
            sclk_q     <= sclk_d;
            bit_cnt_q  <= bit_cnt_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            buf_l_q    <= buf_l_d;
            buf_r_q    <= buf_r_d;
            buf_full_q <= buf_full_d;
            cur_l_q    <= cur_l_d;
            cur_r_q    <= cur_r_d;
            underrun_q <= underrun_d;
            ready_q    <= ready_d;
        end
    end

    assign sample_ready = ready_q;
    assign underrun     = underrun_q;
    assign i2s_mclk     = mclk_q;
    assign i2s_sclk     = sclk_q;
    assign i2s_lrclk    = lrclk_q;
    assign i2s_sdata    = sdata_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: cycle-by-cycle reference model computed from
// elapsed cycles since enable, table of bit-order vectors, directed corner cases.
module tb_i2s_tx_serializer;

    localparam int unsigned SW    = 16;
    localparam int unsigned MH    = 4;
    localparam int unsigned SH    = 16;
    localparam int unsigned FRAME = 128 * SH;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [SW-1:0] sample_left;
    logic [SW-1:0] sample_right;
    logic          sample_valid;
    logic          sample_ready;
    logic          underrun;
    logic          i2s_mclk;
    logic          i2s_sclk;
    logic          i2s_lrclk;
    logic          i2s_sdata;

    int tests = 0;
    int fails = 0;

    i2s_tx_serializer #(
        .SAMPLE_WIDTH(SW),
        .MCLK_HALF   (MH),
        .SCLK_HALF   (SH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .sample_left (sample_left),
        .sample_right(sample_right),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .underrun    (underrun),
        .i2s_mclk    (i2s_mclk),
        .i2s_sclk    (i2s_sclk),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_sdata   (i2s_sdata)
    );

    always #5 clk = ~clk;

    // Reference model state: n = edges since the enabling edge, one-entry buffer.
    bit            m_act;
    int unsigned   m_n;
    bit            m_full;
    logic [SW-1:0] m_bl, m_br, m_cl, m_cr;
    bit            m_ready;
    bit            m_ur;

    // Observations collected while running
    int unsigned ur_at[$];
    int unsigned mclk_rise[$];
    int unsigned sclk_rise[$];
    int unsigned sd_ones;
    int unsigned idle_nz;
    logic        prev_mclk, prev_sclk;

    typedef struct {
        logic [SW-1:0] l;
        logic [SW-1:0] r;
        logic [31:0]   exp_l;
        logic [31:0]   exp_r;
    } vec_t;

    vec_t tbl[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_idle();
        m_act   = 1'b0;
        m_n     = 0;
        m_full  = 1'b0;
        m_cl    = '0;
        m_cr    = '0;
        m_ready = 1'b0;
        m_ur    = 1'b0;
    endtask

    // Expected {ready, underrun, mclk, sclk, lrclk, sdata} after edge n.
    function automatic logic [5:0] model_outs();
        logic [5:0]    o;
        int unsigned   f, b, k;
        logic [SW-1:0] w;
        o = '0;
        if (m_act) begin
            o[5] = m_ready;
            o[4] = m_ur;
            o[3] = (((m_n + 1) / MH) % 2) == 1;
            o[2] = (((m_n + 1) / SH) % 2) == 1;
            f = (m_n + 1) / (2 * SH);
            if (f > 0) begin
                b = (f - 1) % 64;
                k = b % 32;
                w = (b >= 32) ? m_cr : m_cl;
                o[1] = (b >= 32);
                if (k >= 1 && k <= SW) o[0] = w[SW - k];
            end
        end
        return o;
    endfunction

    task automatic model_edge();
        bit          xfer;
        int unsigned f;
        if (rst || !enable) begin
            model_idle();
            return;
        end
        if (!m_act) begin
            m_act = 1'b1;
            m_n   = 0;
        end else begin
            m_n++;
        end
        xfer = sample_valid && m_ready;
        m_ur = 1'b0;
        if ((m_n + 1) % (2 * SH) == 0) begin
            f = (m_n + 1) / (2 * SH);
            if ((f - 1) % 64 == 0) begin
                if (m_full) begin
                    m_cl   = m_bl;
                    m_cr   = m_br;
                    m_full = 1'b0;
                end else begin
                    m_cl = '0;
                    m_cr = '0;
                    m_ur = 1'b1;
                end
            end
        end
        if (xfer) begin
            m_bl   = sample_left;
            m_br   = sample_right;
            m_full = 1'b1;
        end
        m_ready = !m_full;
    endtask

    task automatic tick();
        logic [5:0] act;
        @(posedge clk);
        model_edge();
        #1;
        act = {sample_ready, underrun, i2s_mclk, i2s_sclk, i2s_lrclk, i2s_sdata};
        check("outputs", {58'd0, act}, {58'd0, model_outs()});
        if (m_act) begin
            if (underrun === 1'b1) ur_at.push_back(m_n);
            if (i2s_sdata === 1'b1) sd_ones++;
            if (i2s_mclk === 1'b1 && prev_mclk === 1'b0) mclk_rise.push_back(m_n);
            if (i2s_sclk === 1'b1 && prev_sclk === 1'b0) sclk_rise.push_back(m_n);
        end else if (act !== 6'b0) begin
            idle_nz++;
        end
        prev_mclk = i2s_mclk;
        prev_sclk = i2s_sclk;
    endtask

    // One idle edge, clear observations, then raise enable: the next tick is E0.
    task automatic start_run();
        enable = 1'b0;
        tick();
        ur_at.delete();
        mclk_rise.delete();
        sclk_rise.delete();
        sd_ones = 0;
        enable  = 1'b1;
    endtask

    task automatic tick_until(input int unsigned n);
        for (int i = 0; i < 3 * FRAME && !(m_act && m_n >= n); i++) tick();
        check("tick_until", 64'(m_act && m_n == n), 64'd1);
    endtask

    // Record sdata/lrclk at every falling sclk of frame fr (bit b stored at [63-b]).
    task automatic capture(input int unsigned fr, output logic [63:0] sd, output logic [63:0] lr);
        int unsigned f, b;
        bit          done;
        done = 1'b0;
        sd   = '0;
        lr   = '0;
        for (int i = 0; i < 3 * FRAME && !done; i++) begin
            tick();
            if (m_act && (m_n + 1) % (2 * SH) == 0) begin
                f = (m_n + 1) / (2 * SH);
                if ((f - 1) / 64 == fr) begin
                    b = (f - 1) % 64;
                    sd[63 - b] = i2s_sdata;
                    lr[63 - b] = i2s_lrclk;
                    if (b == 63) done = 1'b1;
                end
            end
        end
        check("capture_done", 64'(done), 64'd1);
    endtask

    initial begin
        logic [63:0] sd, lr;
        logic [5:0]  outs;

        tbl[0] = '{l: 16'hA5F0, r: 16'h0F0F, exp_l: 32'h52F8_0000, exp_r: 32'h0787_8000};
        tbl[1] = '{l: 16'hFFFF, r: 16'h0001, exp_l: 32'h7FFF_8000, exp_r: 32'h0000_8000};
        tbl[2] = '{l: 16'h8000, r: 16'h0000, exp_l: 32'h4000_0000, exp_r: 32'h0000_0000};
        tbl[3] = '{l: 16'h1234, r: 16'hFEDC, exp_l: 32'h091A_0000, exp_r: 32'h7F6E_0000};

        model_idle();
        prev_mclk    = 1'b0;
        prev_sclk    = 1'b0;
        sd_ones      = 0;
        idle_nz      = 0;
        rst          = 1'b1;
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample_left  = '0;
        sample_right = '0;

        // Reset then 100 disabled cycles: everything stays low
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        check("idle_quiet", 64'(idle_nz), 64'd0);

        // Bit order: pair offered on the first boundary edge plays in frame 1
        for (int v = 0; v < 4; v++) begin
            start_run();
            tick_until(30);
            sample_left  = tbl[v].l;
            sample_right = tbl[v].r;
            sample_valid = 1'b1;
            tick();
            sample_valid = 1'b0;
            capture(0, sd, lr);
            check("tbl_frame0_zero", sd, 64'd0);
            capture(1, sd, lr);
            check("tbl_left", 64'(sd[63:32]), 64'(tbl[v].exp_l));
            check("tbl_right", 64'(sd[31:0]), 64'(tbl[v].exp_r));
            check("tbl_lrclk", lr, 64'h0000_0000_FFFF_FFFF);
            check("tbl_ur_count", 64'(ur_at.size()), 64'd1);
            if (ur_at.size() > 0) check("tbl_ur_pos", 64'(ur_at[0]), 64'd31);
        end

        // Underrun and clock periods: three empty frames
        sample_valid = 1'b0;
        start_run();
        for (int i = 0; i < 3 * FRAME; i++) tick();
        check("ur_count", 64'(ur_at.size()), 64'd3);
        if (ur_at.size() == 3) begin
            check("ur_first", 64'(ur_at[0]), 64'd31);
            check("ur_gap1", 64'(ur_at[1] - ur_at[0]), 64'd2048);
            check("ur_gap2", 64'(ur_at[2] - ur_at[1]), 64'd2048);
        end
        check("ur_sdata_zero", 64'(sd_ones), 64'd0);
        check("mclk_first_rise", 64'(mclk_rise[0]), 64'd3);
        check("mclk_period", 64'(mclk_rise[1] - mclk_rise[0]), 64'd8);
        check("sclk_first_rise", 64'(sclk_rise[0]), 64'd15);
        check("sclk_period", 64'(sclk_rise[1] - sclk_rise[0]), 64'd32);

        // Async reset mid-frame: outputs drop before the next clock edge
        tick_until(3 * FRAME + 100);
        @(posedge clk);
        model_edge();
        #3;
        rst = 1'b1;
        #1;
        outs = {sample_ready, underrun, i2s_mclk, i2s_sclk, i2s_lrclk, i2s_sdata};
        check("async_rst", 64'(outs), 64'd0);
        model_idle();
        tick();
        rst = 1'b0;
        tick();

        // Back-pressure: P1 at E0+1, P2 one cycle after the first boundary
        sample_left  = 16'h1234;
        sample_right = 16'h8001;
        sample_valid = 1'b1;
        start_run();
        tick();
        check("bp_ready_e0", 64'(sample_ready), 64'd1);
        tick();
        check("bp_ready_after_p1", 64'(sample_ready), 64'd0);
        sample_left  = 16'hFFFF;
        sample_right = 16'h0000;
        tick_until(31);
        check("bp_ready_boundary", 64'(sample_ready), 64'd1);
        tick();
        check("bp_ready_after_p2", 64'(sample_ready), 64'd0);
        sample_valid = 1'b0;
        capture(0, sd, lr);
        check("bp_frame0", sd, 64'h091A_0000_4000_8000);
        capture(1, sd, lr);
        check("bp_frame1", sd, 64'h7FFF_8000_0000_0000);
        check("bp_no_underrun", 64'(ur_at.size()), 64'd0);

        // Enable drop at slot bit 40 with the buffer full
        sample_left  = 16'h5555;
        sample_right = 16'hAAAA;
        sample_valid = 1'b1;
        start_run();
        tick_until(1);
        sample_left  = 16'h7777;
        sample_right = 16'h3333;
        tick_until(32);
        sample_valid = 1'b0;
        tick_until(41 * 2 * SH - 1);
        check("drop_buf_full", 64'(sample_ready), 64'd0);
        enable = 1'b0;
        tick();
        outs = {sample_ready, underrun, i2s_mclk, i2s_sclk, i2s_lrclk, i2s_sdata};
        check("drop_idle", 64'(outs), 64'd0);
        tick();
        start_run();
        tick();
        check("drop_ready_e0", 64'(sample_ready), 64'd1);
        capture(0, sd, lr);
        check("drop_frame_zero", sd, 64'd0);
        check("drop_ur_count", 64'(ur_at.size()), 64'd1);
        if (ur_at.size() > 0) check("drop_ur_pos", 64'(ur_at[0]), 64'd31);

        // Random traffic with occasional enable drops against the model
        sample_valid = 1'b0;
        start_run();
        for (int i = 0; i < 5 * FRAME; i++) begin
            sample_valid = ($urandom_range(0, 2047) < 3);
            sample_left  = SW'($urandom);
            sample_right = SW'($urandom);
            enable       = ($urandom_range(0, 2999) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
